// File: rtl/gtfmac_vnc_sync_bus_arbiter_pkg.sv
// gtfmac_vnc_sync_arb_pkg: shared FSM states and bus_out field layout for the arbiter and clkout-side decoder
// Layout of bus_out is {toggle, chan_id, data}; bus_fields() returns the bit offsets of each field.
package gtfmac_vnc_sync_arb_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [15:0] toggle_bit;
    logic [15:0] chan_lsb;
    logic [15:0] data_lsb;
  } bus_fields_t;
  function automatic bus_fields_t bus_fields(input int chan_w, input int data_w);
    return '{toggle_bit: 16'(chan_w + data_w), chan_lsb: 16'(data_w), data_lsb: 16'd0};
  endfunction
endpackage

// File: rtl/gtfmac_vnc_sync_bus_arbiter_if.sv
// gtfmac_vnc_sync_bus_arbiter_if: requester-side bus of the syncer arbiter
// Ports: req/req_data from requesters; gnt (one-hot pulse), bus_out {toggle,chan_id,data}, busy back.
// master = requester side, slave = arbiter side.
interface gtfmac_vnc_sync_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int CHAN_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [CHAN_W+DATA_W:0]    bus_out;
  logic                      busy;
  modport master (output req, req_data, input gnt, bus_out, busy);
  modport slave (input req, req_data, output gnt, bus_out, busy);
endinterface

// File: rtl/gtfmac_vnc_sync_bus_arbiter_rr_arbiter.sv
// gtfmac_vnc_rr_arbiter: combinational one-hot winner selection for the syncer bus arbiter
// Ports: req (requests), rr_last (last granted channel) -> win (one-hot), win_idx (encoded).
// GTFMAC_VNC_SYNC_ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module gtfmac_vnc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CHAN_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [CHAN_W-1:0]  rr_last,
  output logic [NUM_REQ-1:0] win,
  output logic [CHAN_W-1:0]  win_idx
);
`ifdef GTFMAC_VNC_SYNC_ARB_STRICT_PRIO_EN
  logic unused_rr_last;
  assign unused_rr_last = ^rr_last;
  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = '0;
        win[i] = 1'b1;
        win_idx = CHAN_W'(i);
      end
    end
  end
`else
  int c;
  logic found;
  // Search order starts just after the last winner, so rr_last itself is checked last.
  always_comb begin
    win = '0;
    win_idx = '0;
    found = 1'b0;
    c = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(rr_last) + i) % NUM_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        win[c] = 1'b1;
        win_idx = CHAN_W'(c);
      end
    end
  end
`endif
endmodule

// File: rtl/gtfmac_vnc_sync_bus_arbiter.sv
// gtfmac_vnc_sync_bus_arbiter: time-multiplexes requester status words onto one bus CDC syncer input
// Ports: clk, reset (async active-high), bus (slave modport: req, req_data in; gnt, bus_out, busy out).
// Build option: GTFMAC_VNC_SYNC_ARB_STRICT_PRIO_EN selects fixed priority in the winner selector.
module gtfmac_vnc_sync_bus_arbiter
  import gtfmac_vnc_sync_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  gtfmac_vnc_sync_bus_arbiter_if.slave bus
);
  localparam int CHAN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam bus_fields_t F = bus_fields(CHAN_W, DATA_W);
  localparam int TOGGLE_BIT = int'(F.toggle_bit);
  localparam int CHAN_LSB = int'(F.chan_lsb);
  localparam int DATA_LSB = int'(F.data_lsb);
  state_t state, state_n;
  logic [CNT_W-1:0] hold_cnt;
  logic [CHAN_W-1:0] rr_last, win_idx;
  logic [NUM_REQ-1:0] win, gnt_q;
  logic [CHAN_W+DATA_W:0] bus_q;
  logic capture;
  gtfmac_vnc_rr_arbiter #(.NUM_REQ(NUM_REQ), .CHAN_W(CHAN_W)) u_arb (
    .req(bus.req),
    .rr_last(rr_last),
    .win(win),
    .win_idx(win_idx)
  );
  // hold_cnt is 0 throughout IDLE, so the end of a hold and IDLE arbitrate identically.
  always_comb begin
    capture = (state == IDLE || hold_cnt == '0) && |bus.req;
    state_n = capture ? HOLD : (hold_cnt == '0 ? IDLE : state);
  end
  // bus_q only changes on capture so the syncer always samples a settled word; the toggle marks each new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      rr_last <= CHAN_W'(NUM_REQ - 1);
      gnt_q <= '0;
      bus_q <= '0;
    end else begin
      state <= state_n;
      gnt_q <= capture ? win : '0;
      if (capture) begin
        bus_q[TOGGLE_BIT] <= ~bus_q[TOGGLE_BIT];
        bus_q[CHAN_LSB +: CHAN_W] <= win_idx;
        bus_q[DATA_LSB +: DATA_W] <= bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
        hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
        rr_last <= win_idx;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.bus_out = bus_q;
  assign bus.busy = (state == HOLD);
endmodule

// File: tb/tb_gtfmac_vnc_sync_bus_arbiter.sv
// tb_gtfmac_vnc_sync_bus_arbiter: self-checking bench for the syncer bus arbiter
module tb_gtfmac_vnc_sync_bus_arbiter;
  typedef struct {logic [3:0] gnt; logic [34:0] bus;} exp_t;
  typedef struct {logic [3:0] req; int ch; logic [31:0] d;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  vec_t tbl[8];
  int total = 0, bad = 0, pushed = 0, seen = 0;
  logic exp_toggle = 1'b0;
  logic [34:0] last_bus = '0;
  gtfmac_vnc_sync_bus_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();
  gtfmac_vnc_sync_bus_arbiter #(.NUM_REQ(4), .DATA_W(32), .HOLD_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_exp(input int ch, input logic [31:0] d);
    exp_toggle = ~exp_toggle;
    last_bus = {exp_toggle, 2'(ch), d};
    q.push_back('{gnt: 4'(1 << ch), bus: last_bus});
    pushed++;
  endtask
  task automatic drive(input logic [3:0] r, input int w, input logic [31:0] d);
    for (int c = 0; c < 4; c++) bus.req_data[c*32 +: 32] = (c == w) ? d : ~d;
    bus.req = r;
  endtask
  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt === 4'b0 && n < 100);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b0 && n < 100);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.gnt !== 4'b0) begin
      seen++;
      if (q.size() == 0) chk("unexpected_gnt", 64'(bus.gnt), 64'd0);
      else begin
        e = q.pop_front();
        chk("gnt", 64'(bus.gnt), 64'(e.gnt));
        chk("bus_out", 64'(bus.bus_out), 64'(e.bus));
        chk("busy_at_gnt", 64'(bus.busy), 64'd1);
      end
    end
  end
  initial begin
    int n, cyc;
    bus.req = '0;
    bus.req_data = '0;
    tbl[0] = '{4'b0100, 2, 32'hA5A5_0001};
    tbl[1] = '{4'b1111, 3, 32'h1234_5678};
    tbl[2] = '{4'b0011, 0, 32'hCAFE_0000};
    tbl[3] = '{4'b0011, 1, 32'hCAFE_0001};
    tbl[4] = '{4'b1001, 3, 32'hFFFF_FFFF};
    tbl[5] = '{4'b0110, 1, 32'h0000_0001};
    tbl[6] = '{4'b0101, 2, 32'h8000_0000};
    tbl[7] = '{4'b0001, 0, 32'h5A5A_5A5A};
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_bus", 64'(bus.bus_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
`ifndef GTFMAC_VNC_SYNC_ARB_STRICT_PRIO_EN
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].ch, tbl[i].d);
      push_exp(tbl[i].ch, tbl[i].d);
      wait_gnt(n);
      chk("latency", 64'(n), 64'd1);
      bus.req = '0;
      wait_idle(n);
      chk("hold_len", 64'(n), 64'd16);
      chk("idle_bus_stable", 64'(bus.bus_out), 64'(last_bus));
    end
    @(negedge clk);
    drive(4'b0010, 1, 32'h0);
    push_exp(1, 32'h0);
    push_exp(1, 32'h0);
    wait_gnt(n);
    chk("repeat_lat", 64'(n), 64'd1);
    wait_gnt(n);
    chk("repeat_gap", 64'(n), 64'd16);
    bus.req = '0;
    wait_idle(n);
    @(negedge clk);
    drive(4'b0001, 0, 32'h1111_0000);
    push_exp(0, 32'h1111_0000);
    wait_gnt(n);
    bus.req = '0;
    bus.req_data[96 +: 32] = 32'hDEAD_0003;
    repeat (5) @(negedge clk);
    bus.req = 4'b1000;
    repeat (3) @(negedge clk);
    bus.req = '0;
    repeat (7) @(negedge clk);
    chk("busy_before_late", 64'(bus.busy), 64'd1);
    bus.req = 4'b1000;
    push_exp(3, 32'hDEAD_0003);
    wait_gnt(n);
    chk("late_lat", 64'(n), 64'd1);
    bus.req = '0;
    wait_idle(n);
`endif
    @(negedge clk);
    drive(4'b0100, 2, 32'h2222_0002);
    push_exp(2, 32'h2222_0002);
    wait_gnt(n);
    bus.req = '0;
    repeat (10) @(negedge clk);
    chk("busy_mid_hold", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 64'(bus.gnt), 64'd0);
    chk("midrst_bus", 64'(bus.bus_out), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    exp_toggle = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) bus.req_data[c*32 +: 32] = 32'hC0DE_0000 + c;
`ifndef GTFMAC_VNC_SYNC_ARB_STRICT_PRIO_EN
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(k % 4, 32'hC0DE_0000 + (k % 4));
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.gnt === 4'b0 && cyc < 200);
      chk("rr_grant_time", 64'(cyc), 64'(1 + 16 * k));
    end
`else
    bus.req = 4'b1010;
    for (int k = 0; k < 3; k++) push_exp(1, 32'hC0DE_0001);
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.gnt === 4'b0 && cyc < 200);
      chk("prio_grant_time", 64'(cyc), 64'(1 + 16 * k));
    end
`endif
    bus.req = '0;
    wait_idle(n);
    chk("final_idle", 64'(bus.busy), 64'd0);
    chk("gnt_count", 64'(seen), 64'(pushed));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
